// File: rtl/dco_pkg.sv
// Shared definitions for the DCO loop: default widths common to the DCO,
// its frequency meter and the future code controller, plus the meter FSM
// state encoding.
package dco_pkg;

    localparam int DCO_CODE_W = 8;
    localparam int GATE_W     = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_t;

endpackage

// File: rtl/dco_sync_edge.sv
// Brings the free-running DCO output into the clk domain and flags its
// rising edges.
//   clk    : system clock
//   rst    : synchronous, active-high reset of all flops
//   dco_in : DCO output, asynchronous to clk
//   rise   : high for one clk cycle per synchronised rising edge
// A dco_in transition shows up on rise SYNC_STAGES cycles later, so it is
// counted on the edge after that.
module dco_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dco_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus the previous-value flop; prev runs every cycle
    // so one physical edge can never be reported twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], dco_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/dco_freq_meter.sv
// Counts DCO rising edges over a programmable gate of clk cycles and hands
// the result back through a start/valid handshake.
//   clk         : system clock
//   rst_n       : synchronous reset, active HIGH despite its name
//   dco_in      : DCO output, asynchronous to clk
//   start       : measurement request, honoured only when idle
//   gate_cycles : gate length N, captured when start is accepted
//   busy        : high while a measurement is in progress
//   count_out   : last result, held until the next measurement completes
//   count_valid : one-cycle pulse when count_out/overflow are refreshed
//   overflow    : last result saturated at all-ones
// Latency from accepted start to count_valid is SYNC_STAGES+N+1 cycles.
// Inputs faster than f_clk/2 alias and are not detected.
module dco_freq_meter
    import dco_pkg::*;
#(
    parameter int GATE_W      = dco_pkg::GATE_W,
    parameter int CNT_W       = dco_pkg::CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dco_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    output logic              overflow
);

    localparam int ARM_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES - 1);
    localparam logic [ARM_W-1:0]  ARM_ONE  = ARM_W'(1'b1);
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    meter_state_t      state_r, state_next_s;
    logic [ARM_W-1:0]  arm_cnt_r, arm_next_s;
    logic [GATE_W-1:0] gate_cnt_r, gate_next_s;
    logic [CNT_W-1:0]  edge_cnt_r, edge_next_s;
    logic              ovf_r, ovf_next_s;
    logic              rise_s;
    logic              busy_r, count_valid_r, overflow_r;
    logic [CNT_W-1:0]  count_out_r;

    dco_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst_n),
        .dco_in (dco_in),
        .rise   (rise_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic together with the gate, arm and edge counter updates.
    always_comb begin
        state_next_s = state_r;
        arm_next_s   = arm_cnt_r;
        gate_next_s  = gate_cnt_r;
        edge_next_s  = edge_cnt_r;
        ovf_next_s   = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ARM;
                    arm_next_s   = '0;
                    gate_next_s  = gate_cycles;
                    edge_next_s  = '0;
                    ovf_next_s   = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Edges seen while the synchroniser flushes are ignored.
                if (arm_cnt_r == ARM_LAST) begin
                    if (gate_cnt_r == '0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end else begin
                    arm_next_s = arm_cnt_r + ARM_ONE;
                end
            end
            ST_MEASURE: begin
                gate_next_s = gate_cnt_r - GATE_ONE;
                if (rise_s) begin
                    if (edge_cnt_r == CNT_MAX) begin
                        ovf_next_s = 1'b1;
                    end else begin
                        edge_next_s = edge_cnt_r + CNT_ONE;
                    end
                end else begin
                    edge_next_s = edge_cnt_r;
                end
                if (gate_cnt_r == GATE_ONE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MEASURE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Working counters of the measurement in progress.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            arm_cnt_r  <= '0;
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else begin
            arm_cnt_r  <= arm_next_s;
            gate_cnt_r <= gate_next_s;
            edge_cnt_r <= edge_next_s;
            ovf_r      <= ovf_next_s;
        end
    end

    // Registered outputs, derived from the next state so they line up with
    // the state they describe; the result is captured on entry to DONE,
    // including any edge seen in the final gate cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_r        <= 1'b0;
            count_valid_r <= 1'b0;
            count_out_r   <= '0;
            overflow_r    <= 1'b0;
        end else begin
            busy_r        <= (state_next_s != ST_IDLE);
            count_valid_r <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                count_out_r <= edge_next_s;
                overflow_r  <= ovf_next_s;
            end else begin
                count_out_r <= count_out_r;
                overflow_r  <= overflow_r;
            end
        end
    end

    assign busy        = busy_r;
    assign count_valid = count_valid_r;
    assign count_out   = count_out_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Directed bench for dco_freq_meter: a default-width instance (a) and a
// CNT_W=4 instance (b) share clk, reset, dco_in and gate_cycles.
module tb_dco_freq_meter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dco_in = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] gate_cycles = 16'd0;
    logic        busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int dco_mode = 0;
    int dco_ph = 0;

    dco_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(SYNC)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .start(start_a),
        .gate_cycles(gate_cycles), .busy(busy_a), .count_out(cnt_a),
        .count_valid(valid_a), .overflow(ovf_a)
    );

    dco_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(SYNC)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .start(start_b),
        .gate_cycles(gate_cycles), .busy(busy_b), .count_out(cnt_b),
        .count_valid(valid_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // DCO model: 0 low, 1 high, 2 f_clk/4, 3 f_clk/2; moves mid-cycle.
    always @(posedge clk) begin
        #3;
        case (dco_mode)
            0: dco_in = 1'b0;
            1: dco_in = 1'b1;
            2: begin
                dco_ph = dco_ph + 1;
                if (dco_ph >= 2) begin
                    dco_ph = 0;
                    dco_in = ~dco_in;
                end
            end
            3: dco_in = ~dco_in;
            default: dco_in = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle(input int mode);
        dco_mode = mode;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // act: 0 plain run, 1 poke start and gate_cycles during MEASURE.
    task automatic run_meas(input string name, input bit sel, input int n,
                            input int exp_cnt, input bit exp_ovf, input int act);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        gate_cycles = 16'(n);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        while (!seen && cyc < n + SYNC + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
                chk({name, "_busy_up"}, 32'(sel ? busy_b : busy_a), 32'd1);
            end
            if (act == 1 && cyc == SYNC + 20) begin
                start_a = 1'b1;
                gate_cycles = 16'd10;
            end
            if (act == 1 && cyc == SYNC + 21) start_a = 1'b0;
            if (sel ? valid_b : valid_a) seen = 1'b1;
        end
        chk({name, "_valid_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(SYNC + n + 1));
        chk({name, "_count"}, sel ? 32'(cnt_b) : 32'(cnt_a), 32'(exp_cnt));
        chk({name, "_ovf"}, 32'(sel ? ovf_b : ovf_a), 32'(exp_ovf));
        @(posedge clk);
        #1;
        chk({name, "_busy_down"}, 32'(sel ? busy_b : busy_a), 32'd0);
        chk({name, "_valid_pulse"}, 32'(sel ? valid_b : valid_a), 32'd0);
    endtask

    typedef struct {
        string name;
        bit    sel;
        int    mode;
        int    n;
        int    exp_cnt;
        bit    exp_ovf;
        int    act;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int vcyc[3];
        int nv;
        int cyc;
        int spurious;

        vecs[0] = '{"f4_n100",       1'b0, 2, 100, 25, 1'b0, 0};
        vecs[1] = '{"high_n50",      1'b0, 1, 50,  0,  1'b0, 0};
        vecs[2] = '{"n0",            1'b0, 2, 0,   0,  1'b0, 0};
        vecs[3] = '{"f4_n20",        1'b0, 2, 20,  5,  1'b0, 0};
        vecs[4] = '{"f2_n10",        1'b0, 3, 10,  5,  1'b0, 0};
        vecs[5] = '{"c4_f2_n40",     1'b1, 3, 40,  15, 1'b1, 0};
        vecs[6] = '{"c4_f2_n30",     1'b1, 3, 30,  15, 1'b0, 0};
        vecs[7] = '{"c4_f2_n32",     1'b1, 3, 32,  15, 1'b1, 0};
        vecs[8] = '{"ignore_inputs", 1'b0, 2, 100, 25, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_count_b", 32'(cnt_b), 32'd0);

        for (int i = 0; i < 9; i++) begin
            settle(vecs[i].mode);
            run_meas(vecs[i].name, vecs[i].sel, vecs[i].n, vecs[i].exp_cnt,
                     vecs[i].exp_ovf, vecs[i].act);
        end

        // Reset in MEASURE cycle 30 aborts without a result.
        settle(2);
        gate_cycles = 16'd100;
        start_a = 1'b1;
        for (int c = 1; c <= SYNC + 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start_a = 1'b0;
        end
        chk("abort_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_count", 32'(cnt_a), 32'd0);
        chk("abort_valid", 32'(valid_a), 32'd0);
        spurious = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (valid_a || busy_a) spurious++;
        end
        chk("abort_no_valid", 32'(spurious), 32'd0);
        run_meas("after_abort", 1'b0, 100, 25, 1'b0, 0);

        // Back-to-back with start held high.
        settle(2);
        gate_cycles = 16'd20;
        start_a = 1'b1;
        nv = 0;
        cyc = 0;
        while (nv < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (valid_a) begin
                vcyc[nv] = cyc;
                nv++;
                chk("b2b_count", 32'(cnt_a), 32'd5);
                if (nv == 3) start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        chk("b2b_pulses", 32'(nv), 32'd3);
        if (nv == 3) begin
            chk("b2b_first", 32'(vcyc[0]), 32'(SYNC + 21));
            chk("b2b_gap1", 32'(vcyc[1] - vcyc[0]), 32'(SYNC + 22));
            chk("b2b_gap2", 32'(vcyc[2] - vcyc[1]), 32'(SYNC + 22));
        end
        @(posedge clk);
        #1;
        chk("b2b_idle", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
